// File: rtl/mpi_access_ctrl.sv
// mpi_access_ctrl: sequences async CPU bus (MPI) accesses onto one-hot internal register slaves with ack timeout.
module mpi_access_ctrl #(
    parameter int ADDR_W = 25,
    parameter int N_SLV = 7,
    parameter int SETTLE_CYC = 2,
    parameter int TO_CYC = 64,
    parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
    input  logic                clk100m,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   mpi_a,
    input  logic [15:0]         mpi_din,
    input  logic                mpi_cs,
    input  logic                mpi_wr,
    output logic [15:0]         mpi_dout,
    output logic                mpi_en,
    output logic [ADDR_W-4:0]   cpu_addr,
    output logic [15:0]         cpu_dout,
    output logic [N_SLV-1:0]    cpu_cs,
    output logic                cpu_wen,
    output logic                cpu_ren,
    input  logic [16*N_SLV-1:0] cpu_din,
    input  logic [N_SLV-1:0]    cpu_ack,
    input  logic                err_clr,
    output logic                acc_err,
    output logic                busy
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TO_CYC);
    typedef enum logic [2:0] {IDLE, SETTLE, ACCESS, WAIT_ACK, HOLD} state_t;
    state_t state, state_nx;
    logic cs_m, cs_s, wr_m, wr_s, armed, wr;
    logic [SW-1:0] cnt;
    logic [TW-1:0] to_cnt;
    logic [ADDR_W-1:0] addr;
    logic [2:0] idx;
    logic [N_SLV-1:0] sel;
    logic [15:0] rd_data;
    logic mapped, ack_hit, settled, timed_out, err_set;
    assign idx = addr[ADDR_W-1 -: 3];
    assign mapped = {1'b0, idx} < 4'(N_SLV);
    assign settled = cnt == SW'(SETTLE_CYC - 1);
    assign timed_out = to_cnt == TW'(TO_CYC - 1);
    assign cpu_addr = addr[ADDR_W-4:0];
    assign busy = state != IDLE;
    assign cpu_cs = (state == ACCESS || state == WAIT_ACK) ? sel : '0;
    assign cpu_wen = state == ACCESS && mapped && wr;
    assign cpu_ren = state == ACCESS && mapped && !wr;
    assign err_set = (state == ACCESS && !mapped) || (state == WAIT_ACK && !ack_hit && timed_out);
    // only the selected slave's ack and data are looked at
    always_comb begin
        sel = '0;
        rd_data = '0;
        ack_hit = 1'b0;
        for (int k = 0; k < N_SLV; k++) begin
            if (idx == 3'(k)) begin
                sel[k] = 1'b1;
                rd_data = cpu_din[16*k +: 16];
                ack_hit = cpu_ack[k];
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = (armed && cs_s) ? SETTLE : IDLE;
            SETTLE:   state_nx = !cs_s ? IDLE : settled ? ACCESS : SETTLE;
            ACCESS:   state_nx = mapped ? WAIT_ACK : HOLD;
            WAIT_ACK: state_nx = (ack_hit || timed_out) ? HOLD : WAIT_ACK;
            HOLD:     state_nx = cs_s ? HOLD : IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    // strobe synchronizer resets to "active" so a strobe held low through reset must be released before arming
    always_ff @(posedge clk100m) begin
        if (rst) begin
            state <= IDLE;
            armed <= 1'b0;
            cnt <= '0;
            to_cnt <= '0;
            addr <= '0;
            cpu_dout <= '0;
            wr <= 1'b0;
            mpi_dout <= '0;
            mpi_en <= 1'b0;
            acc_err <= 1'b0;
            cs_m <= 1'b1;
            cs_s <= 1'b1;
            wr_m <= 1'b0;
            wr_s <= 1'b0;
        end else begin
            cs_m <= ~mpi_cs;
            cs_s <= cs_m;
            wr_m <= mpi_wr;
            wr_s <= wr_m;
            state <= state_nx;
            armed <= armed | ~cs_s;
            cnt <= state == SETTLE ? cnt + 1'b1 : '0;
            to_cnt <= state == WAIT_ACK ? to_cnt + 1'b1 : '0;
            if (state == SETTLE && state_nx == ACCESS) begin
                addr <= mpi_a;
                cpu_dout <= mpi_din;
                wr <= wr_s;
            end
            if (state == WAIT_ACK && ack_hit && !wr)
                mpi_dout <= rd_data;
            else if (err_set && !wr)
                mpi_dout <= ERR_DATA;
            acc_err <= err_set | (acc_err & ~err_clr);
            mpi_en <= state_nx == HOLD && !wr;
        end
    end
endmodule

// File: doc/mpi_access_ctrl.md
Name: mpi_access_ctrl

Overview:
- Sequencer between the external asynchronous CPU bus (MPI) and the internal register sub-blocks on clk100m.
- Synchronizes and debounces the CPU strobe, then decodes the top address bits to a one-hot sub-block select.
- Issues single-cycle write/read enables and waits for a per-slave acknowledge, with timeout.
- Returns read data and drives the external data-bus enable until the CPU releases the strobe.

Parameters:
ADDR_W, 25, external address width
N_SLV, 7, number of register sub-blocks; must be ≤8
SETTLE_CYC, 2, cycles cs_s must stay asserted before the access is accepted (≥1)
TO_CYC, 64, acknowledge timeout in cycles (≥2)
ERR_DATA, 16'hDEAD, read data returned on timeout or unmapped access

Ports:
clk100m  in  1  system clock
rst  in  1  synchronous active-high reset
mpi_a  in  ADDR_W  CPU address, async
mpi_din  in  16  CPU write data, async
mpi_cs  in  1  CPU chip select, active-low, async
mpi_wr  in  1  1=write, 0=read, async
mpi_dout  out  16  read data to CPU
mpi_en  out  1  external data-bus output enable, read only
cpu_addr  out  ADDR_W-3  local register address = captured mpi_a[ADDR_W-4:0]
cpu_dout  out  16  captured write data
cpu_cs  out  N_SLV  one-hot slave select
cpu_wen  out  1  single-cycle write strobe
cpu_ren  out  1  single-cycle read strobe
cpu_din  in  16*N_SLV  slave read data, slave k at [16k+15:16k]
cpu_ack  in  N_SLV  per-slave completion
err_clr  in  1  clears acc_err
acc_err  out  1  sticky error flag: timeout or unmapped
busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Clock and reset: one clock, clk100m. Reset rst is synchronous, active-high.
- Reset values: all outputs 0; mpi_dout=0; state IDLE; armed=0.
- Synchronizers: cs_s = ~mpi_cs through 2 flops; wr_s = mpi_wr through 2 flops. mpi_a and mpi_din are sampled only on entry to ACCESS.
- Arming: armed is set when cs_s=0. IDLE ignores cs_s=1 while armed=0. This applies after reset with the strobe already low, so no half transaction is accepted.
- FSM states: IDLE, SETTLE, ACCESS, WAIT_ACK, HOLD.
- IDLE: armed and cs_s=1 → SETTLE, cnt=0.
- SETTLE: cs_s=0 → IDLE (glitch; no strobe issued). Otherwise cnt++. When cnt=SETTLE_CYC-1 → ACCESS, capturing:
  - addr ← mpi_a
  - data ← mpi_din
  - wr ← wr_s
  - idx ← mpi_a[ADDR_W-1:ADDR_W-3]
- ACCESS (exactly 1 cycle), unmapped case (idx ≥ N_SLV):
  - No cpu_cs and no strobe.
  - acc_err ← 1.
  - On a read, mpi_dout ← ERR_DATA.
  - Next state HOLD.
- ACCESS, mapped case:
  - cpu_cs[idx]=1.
  - cpu_wen=wr and cpu_ren=~wr, for this cycle only.
  - Next state WAIT_ACK, to_cnt=0.
- WAIT_ACK:
  - cpu_cs[idx] stays high; cpu_addr and cpu_dout are stable.
  - Only cpu_ack[idx] is observed; other ack bits are ignored. Acks during ACCESS are ignored, so the minimum ack latency is 1 cycle after the strobe.
  - cpu_ack[idx]=1: on a read, mpi_dout ← cpu_din slice idx. Next state HOLD.
  - Else to_cnt++. At to_cnt=TO_CYC-1 with no ack: acc_err ← 1; on a read, mpi_dout ← ERR_DATA; next state HOLD.
- HOLD:
  - cpu_cs=0.
  - mpi_en = ~wr, registered, asserted from the cycle HOLD is entered.
  - cs_s=0 → IDLE; mpi_en drops on the same edge.
- Latency: let edge N be the first edge at which mpi_cs is sampled low. cs_s=1 after edge N+1; SETTLE is entered at edge N+2; ACCESS (cpu_wen/cpu_ren high) follows at edge N+2+SETTLE_CYC.
- CPU releases the strobe early (cs_s=0 during ACCESS or WAIT_ACK): the internal transaction still completes or times out; HOLD then exits on the next cycle.
- Error flag: err_clr clears acc_err. If err_clr and a new error occur in the same cycle, the error wins (acc_err=1).
- No new transaction starts until HOLD is exited; back-to-back CPU cycles need the strobe deasserted for ≥1 synchronized cycle.
- Reset mid-transaction: all outputs return to reset values at the next edge. Any strobe already issued is not retracted.

Test Plan:
- Write: SETTLE_CYC=2; mpi_a=25'h0400010, mpi_din=16'h1234, mpi_wr=1, mpi_cs low; slave 1 acks after 3 cycles → cpu_cs=7'b0000010, cpu_wen high exactly 1 cycle at edge N+4, cpu_addr=22'h000010, cpu_dout=16'h1234, mpi_en stays 0.
- Read: slave 6 (mpi_a[24:22]=3'b110) returns 16'hBEEF with ack 1 cycle after cpu_ren → mpi_dout=16'hBEEF, mpi_en=1 until cs_s=0, then mpi_en=0 and busy=0.
- Timeout: TO_CYC=64, read slave 2 with no ack → after 64 WAIT_ACK cycles mpi_dout=16'hDEAD, acc_err=1. Pulse err_clr → acc_err=0.
- Unmapped: mpi_a[24:22]=3'b111, read → no cpu_cs and no cpu_ren, mpi_dout=16'hDEAD, acc_err=1.
- Glitch: mpi_cs low for 1 clk100m cycle → no cpu_wen/cpu_ren, FSM back to IDLE, busy returns to 0.
- Reset with strobe held: rst during WAIT_ACK while mpi_cs stays low → outputs zero next cycle, no new access; mpi_cs high then low again → normal access proceeds.
